// File: rtl/axil_rd_master.sv
`default_nettype none
// ============================================================================
// Module   : axil_rd_master
// Purpose  : Single-outstanding AXI4-lite read initiator. Takes word read
//            requests on a valid/ready port, issues AR, collects R and
//            returns data plus a 2-bit response code. A per-transaction
//            response timeout aborts the wait, and any late R beat is drained
//            so the AXI handshake always completes.
// Revision : 1.0 - initial release
// ============================================================================
module axil_rd_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    // request / response port
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_err,
    output logic                  busy,
    // AXI4-lite read channels
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);

    localparam int c_lsb_w = $clog2(STRB_WIDTH);
    // Wide enough to hold TIMEOUT; kept at least one bit when disabled
    localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TIMEOUT - 1);

    localparam logic [1:0] c_err_slv = 2'b10;
    localparam logic [1:0] c_err_dec = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_drain;
    logic                  r_arvalid;
    logic                  r_rready;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [1:0]            r_rsp_err;
    logic [c_cnt_w-1:0]    r_cnt;

    logic                  w_req_ready;
    logic                  w_misaligned;
    logic                  w_timeout_hit;

    // A request may only be taken when idle and no abandoned R beat is owed
    assign w_req_ready = (r_state == S_IDLE) && !r_drain;

    generate
        if (c_lsb_w > 0) begin : g_align_chk
            assign w_misaligned = |req_addr[c_lsb_w-1:0];
        end else begin : g_align_none
            assign w_misaligned = 1'b0;
        end
    endgenerate

    // Timeout fires in the last allowed DATA cycle only if no beat arrives;
    // a beat in that same cycle takes priority.
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout_hit = (r_state == S_DATA) && !axi_rvalid &&
                                   (r_cnt == c_to_last);
        end else begin : g_timeout_off
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    // Transaction FSM with registered AXI and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drain     <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_araddr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= '0;
            r_cnt       <= '0;
        end else begin
            // The first beat after an abort belongs to the abandoned read
            if (r_drain && axi_rvalid) begin
                r_drain  <= 1'b0;
                r_rready <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (req_valid && w_req_ready) begin
                        r_araddr <= req_addr;
                        if (w_misaligned) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= '0;
                            r_rsp_err   <= c_err_slv;
                            r_state     <= S_RESP;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end
                    end
                end

                S_AR: begin
                    // arvalid is held until accepted; no timeout here
                    if (axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (axi_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= axi_rresp;
                        r_rsp_data  <= (axi_rresp == 2'b00) ? axi_rdata : '0;
                        r_state     <= S_RESP;
                    end else if (w_timeout_hit) begin
                        // rready stays high so the late beat is absorbed
                        r_drain     <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= c_err_dec;
                        r_rsp_data  <= '0;
                        r_state     <= S_RESP;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = w_req_ready;
    assign busy        = (r_state != S_IDLE) || r_drain;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign axi_araddr  = r_araddr;
    assign axi_arvalid = r_arvalid;
    assign axi_rready  = r_rready;

endmodule
`default_nettype wire
